// File: rtl/intersection_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module      : intersection_ctrl
//  Description : Two-road traffic light controller with a pedestrian walk
//                phase on the EW green.
//                Phase order: AR_EW -> NS_G -> NS_Y -> AR_NS -> EW_G -> EW_Y.
//                Each phase is timed by a tick-driven dwell counter.
//                NS green rests until an EW vehicle or a pending pedestrian
//                request is present.
//  Revision    : 1.0  initial release
//------------------------------------------------------------------------------
module intersection_ctrl #(
   parameter int G_TIME  = 8,
   parameter int Y_TIME  = 3,
   parameter int AR_TIME = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       ew_req,
   input  logic       ped_req,
   output logic       ns_r,
   output logic       ns_y,
   output logic       ns_g,
   output logic       ew_r,
   output logic       ew_y,
   output logic       ew_g,
   output logic       walk,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      AR_EW = 3'd0,
      NS_G  = 3'd1,
      NS_Y  = 3'd2,
      AR_NS = 3'd3,
      EW_G  = 3'd4,
      EW_Y  = 3'd5
   } state_t;

   // Last counter value of each dwell. A phase exits on the tick that
   // samples this value, so it lasts exactly N tick pulses.
   localparam logic [3:0] c_G_LAST  = 4'(G_TIME - 1);
   localparam logic [3:0] c_Y_LAST  = 4'(Y_TIME - 1);
   localparam logic [3:0] c_AR_LAST = 4'(AR_TIME - 1);

   state_t     r_state;
   logic [3:0] r_cnt;
   logic       r_ped_pend;
   logic       r_walk_ph;

   state_t     w_state_nxt;
   logic [3:0] w_last;
   logic       w_done;
   logic       w_enter_ewg;
   logic [3:0] w_cnt_nxt;

   // Select the terminal count of the current phase's dwell.
   always_comb begin
      w_last = c_AR_LAST;
      case (r_state)
         NS_G, EW_G: w_last = c_G_LAST;
         NS_Y, EW_Y: w_last = c_Y_LAST;
         default:    w_last = c_AR_LAST;
      endcase
   end

   assign w_done = tick && (r_cnt == w_last);

   // Next-state logic and lamp decode of the registered state.
   always_comb begin
      w_state_nxt = r_state;
      ns_r        = 1'b1;
      ns_y        = 1'b0;
      ns_g        = 1'b0;
      ew_r        = 1'b1;
      ew_y        = 1'b0;
      ew_g        = 1'b0;
      walk        = 1'b0;
      case (r_state)
         AR_EW: begin
            if (w_done) w_state_nxt = NS_G;
         end
         NS_G: begin
            ns_r = 1'b0;
            ns_g = 1'b1;
            // Green rests here until someone on the cross street wants it.
            if (w_done && (ew_req || r_ped_pend)) w_state_nxt = NS_Y;
         end
         NS_Y: begin
            ns_r = 1'b0;
            ns_y = 1'b1;
            if (w_done) w_state_nxt = AR_NS;
         end
         AR_NS: begin
            if (w_done) w_state_nxt = EW_G;
         end
         EW_G: begin
            ew_r = 1'b0;
            ew_g = 1'b1;
            walk = r_walk_ph;
            if (w_done) w_state_nxt = EW_Y;
         end
         EW_Y: begin
            ew_r = 1'b0;
            ew_y = 1'b1;
            if (w_done) w_state_nxt = AR_EW;
         end
         default: begin
            // Unused codes recover to all-red on the next edge.
            w_state_nxt = AR_EW;
         end
      endcase
   end

   assign state_o     = r_state;
   assign w_enter_ewg = (w_state_nxt == EW_G) && (r_state != EW_G);

   // Dwell counter: clears on any phase change, saturates at the terminal count.
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_state_nxt != r_state) begin
         w_cnt_nxt = 4'd0;
      end else if (tick && (r_cnt != w_last)) begin
         w_cnt_nxt = r_cnt + 4'd1;
      end
   end

   // State, counter and pedestrian flag registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= AR_EW;
         r_cnt      <= 4'd0;
         r_ped_pend <= 1'b0;
         r_walk_ph  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_enter_ewg) begin
            // A press on the entry edge is served by this walk phase.
            r_walk_ph  <= r_ped_pend | ped_req;
            r_ped_pend <= 1'b0;
         end else begin
            r_ped_pend <= r_ped_pend | ped_req;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_intersection_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module      : tb_intersection_ctrl
//  Description : Scoreboard bench for intersection_ctrl with a phase-list
//                reference model, directed scenarios and random traffic.
//  Revision    : 1.0  initial release
//------------------------------------------------------------------------------
module tb_intersection_ctrl;

   localparam int G_TIME  = 8;
   localparam int Y_TIME  = 3;
   localparam int AR_TIME = 1;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       tick = 1'b0;
   logic       ew_req = 1'b0;
   logic       ped_req = 1'b0;
   logic       ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk;
   logic [2:0] state_o;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [2:0] st;
      logic [6:0] lamps;   // {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g,walk}
   } exp_t;

   exp_t q[$];

   // Reference model: phase index 0..5 in road order, ticks seen in phase.
   int   dwell [6] = '{AR_TIME, G_TIME, Y_TIME, AR_TIME, G_TIME, Y_TIME};
   int   m_ph    = 0;
   int   m_ticks = 0;
   bit   m_pend  = 0;
   bit   m_walk  = 0;

   intersection_ctrl #(
      .G_TIME (G_TIME),
      .Y_TIME (Y_TIME),
      .AR_TIME(AR_TIME)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .ew_req (ew_req),
      .ped_req(ped_req),
      .ns_r   (ns_r),
      .ns_y   (ns_y),
      .ns_g   (ns_g),
      .ew_r   (ew_r),
      .ew_y   (ew_y),
      .ew_g   (ew_g),
      .walk   (walk),
      .state_o(state_o)
   );

   always #5 clk = ~clk;

   function automatic exp_t model_out();
      exp_t e;
      e.st = 3'(m_ph);
      e.lamps = {m_ph != 1 && m_ph != 2, m_ph == 2, m_ph == 1,
                 m_ph != 4 && m_ph != 5, m_ph == 5, m_ph == 4,
                 m_ph == 4 && m_walk};
      return e;
   endfunction

   task automatic model_reset();
      m_ph = 0; m_ticks = 0; m_pend = 0; m_walk = 0;
   endtask

   // Advance the model by one clock edge with the given inputs.
   task automatic model_edge(input bit t, input bit e, input bit p);
      bit old_pend;
      bit leave;
      old_pend = m_pend;
      if (!reset) begin
         model_reset();
         return;
      end
      leave = t && (m_ticks + 1 >= dwell[m_ph]) && (m_ph != 1 || e || old_pend);
      if (leave) begin
         m_ph = (m_ph + 1) % 6;
         m_ticks = 0;
      end else if (t) begin
         m_ticks++;
      end
      if (leave && m_ph == 4) begin
         m_walk = old_pend | p;
         m_pend = 0;
      end else begin
         m_pend = old_pend | p;
      end
   endtask

   // One clock: apply inputs, queue the expected post-edge outputs.
   task automatic step(input bit t, input bit e, input bit p);
      tick = t; ew_req = e; ped_req = p;
      model_edge(t, e, p);
      q.push_back(model_out());
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string name);
      logic [9:0] act;
      act = {state_o, ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk};
      checks++;
      if (act !== {3'd0, 7'b1001000}) begin
         failures++;
         $display("FAIL %s: got %b required %b", name, act, {3'd0, 7'b1001000});
      end
   endtask

   // Monitor: compare DUT outputs against the scoreboard and check invariants.
   always @(negedge clk) begin
      exp_t e;
      logic [6:0] act;
      act = {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk};
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if (state_o !== e.st || act !== e.lamps) begin
            failures++;
            $display("FAIL scoreboard @%0t: state=%0d lamps=%b required state=%0d lamps=%b",
                     $time, state_o, act, e.st, e.lamps);
         end
      end
      checks++;
      if ((ns_g | ns_y) & (ew_g | ew_y)) begin
         failures++;
         $display("FAIL conflict @%0t: ns_g/y=%b%b ew_g/y=%b%b required no overlap",
                  $time, ns_g, ns_y, ew_g, ew_y);
      end
      checks++;
      if ((32'(ns_r) + ns_y + ns_g) != 1 || (32'(ew_r) + ew_y + ew_g) != 1) begin
         failures++;
         $display("FAIL one_lamp @%0t: ns=%b%b%b ew=%b%b%b required one-hot per road",
                  $time, ns_r, ns_y, ns_g, ew_r, ew_y, ew_g);
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit   reached;
      // Reset values while reset is held.
      #1;
      check_reset_outputs("reset_values");
      @(negedge clk); #1;
      step(1, 0, 0);
      step(1, 0, 0);
      reset = 1'b1;

      // No requests: one tick to NS_G, then NS_G rests indefinitely.
      for (int i = 0; i < 40; i++) step(1, 0, 0);

      // EW vehicle held: full cycle through all phases.
      for (int i = 0; i < 60; i++) step(1, 1, 0);

      // Park in NS_G, then a single pedestrian pulse.
      for (int i = 0; i < 40; i++) step(1, 0, 0);
      step(1, 0, 1);
      reached = 0;
      for (int i = 0; i < 200 && !reached; i++) begin
         if (m_ph == 4 && m_ticks == 3) reached = 1;
         else step(1, 0, 0);
      end
      checks++;
      if (!reached || !walk) begin
         failures++;
         $display("FAIL reach_walk: reached=%0d walk=%b required reached=1 walk=1", reached, walk);
      end

      // Asynchronous reset during a walk phase: all-red immediately.
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      model_reset();
      step(1, 1, 1);
      step(1, 1, 0);
      reset = 1'b1;

      // Slow tick: one tick every 4th cycle, vehicle waiting.
      for (int i = 0; i < 240; i++) step((i % 4) == 3, 1, (i % 97) == 50);

      // Randomized traffic.
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 15) == 0) ew_req = ~ew_req;
         step($urandom_range(0, 2) != 0, ew_req, $urandom_range(0, 29) == 0);
      end

      @(negedge clk); #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
